spi_frame_receiver: RTL and testbench

SPI slave receiver for the SAP-1 debug link, the receiving end of the 40-bit status frame the SAP-1 top-level SPI master emits. It runs in the 100 MHz system domain and oversamples the asynchronous `sclk`/`mosi`/`cs_n` lines. Each frame is deserialized MSB-first and split into the SAP-1 status fields. Complete frames are flagged with a single-cycle strobe. Loopback benches use it to check the master, and a second FPGA uses it as a monitor.

---
 rtl/spi_frame_receiver_if.sv | 31 +++
 rtl/spi_frame_receiver.sv | 170 +++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_frame_receiver_if.sv
// Bundle of SPI pins and decoded frame outputs for spi_frame_receiver.
// master = SPI master / frame consumer side, slave = the receiver itself.
interface spi_frame_receiver_if #(
    parameter int FRAME_BITS = 40
);
    logic                  sclk;
    logic                  mosi;
    logic                  cs_n;
    logic [FRAME_BITS-1:0] frame_data;
    logic [7:0]            a_val;
    logic [7:0]            b_val;
    logic [7:0]            acc_val;
    logic [3:0]            pc_val;
    logic [2:0]            state_val;
    logic                  frame_valid;
    logic                  frame_err;
    logic [15:0]           frame_count;
    logic                  busy;

    modport master (
        output sclk, mosi, cs_n,
        input  frame_data, a_val, b_val, acc_val, pc_val, state_val,
        input  frame_valid, frame_err, frame_count, busy
    );

    modport slave (
        input  sclk, mosi, cs_n,
        output frame_data, a_val, b_val, acc_val, pc_val, state_val,
        output frame_valid, frame_err, frame_count, busy
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// Oversampling SPI slave that receives the SAP-1 40-bit status frame.
// Optional reserved-bit/state validation is enabled with SPI_RX_FORMAT_CHECK_EN.
module spi_frame_receiver #(
    parameter int FRAME_BITS     = 40,
    parameter bit SAMPLE_FALLING = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_frame_receiver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] FRAME_BITS_W = 6'(FRAME_BITS);

`ifdef SPI_RX_FORMAT_CHECK_EN
    function automatic logic format_ok(input logic [3:0] rsv_hi,
                                       input logic [4:0] rsv_lo,
                                       input logic [2:0] st);
        format_ok = (rsv_hi == 4'd0) && (rsv_lo == 5'd0) && (st <= 3'd5);
    endfunction
`endif

    state_t                state_r, state_next_s;
    logic [2:0]            sclk_sync_r, cs_sync_r;
    logic [1:0]            mosi_sync_r;
    logic [1:0]            settle_r;
    logic [FRAME_BITS-1:0] shreg_r, frame_data_r;
    logic [5:0]            cnt_r;
    logic [15:0]           frame_count_r;
    logic                  frame_valid_r, frame_err_r, busy_r;
    logic                  sclk_edge_s, cs_fall_s, cs_rise_s, frame_ok_s;
    logic                  start_s, accept_s, reject_s, shift_en_s;

    // Input synchronizers; index 1 is the synced value, index 2 the previous one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b111;
            mosi_sync_r <= 2'b00;
            settle_r    <= 2'd0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], bus.sclk};
            cs_sync_r   <= {cs_sync_r[1:0], bus.cs_n};
            mosi_sync_r <= {mosi_sync_r[0], bus.mosi};
            if (settle_r != 2'd3) begin
                settle_r <= settle_r + 2'd1;
            end
        end
    end

    // A cs_n already low at reset release looks like a falling edge through the
    // reset-valued synchronizer; settle_r masks it so that frame is discarded.
    assign cs_fall_s   = (settle_r == 2'd3) & cs_sync_r[2] & ~cs_sync_r[1];
    assign cs_rise_s   = ~cs_sync_r[2] & cs_sync_r[1];
    assign sclk_edge_s = SAMPLE_FALLING ? (sclk_sync_r[2] & ~sclk_sync_r[1])
                                        : (~sclk_sync_r[2] & sclk_sync_r[1]);
    assign shift_en_s  = (state_r == SHIFT) & sclk_edge_s;

`ifdef SPI_RX_FORMAT_CHECK_EN
    assign frame_ok_s = (cnt_r >= FRAME_BITS_W) &&
                        format_ok(shreg_r[15:12], shreg_r[7:3], shreg_r[2:0]);
`else
    assign frame_ok_s = (cnt_r >= FRAME_BITS_W);
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and frame resolution
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    state_next_s = SHIFT;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cs_rise_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (frame_ok_s) begin
                    accept_s = 1'b1;
                end else begin
                    reject_s = 1'b1;
                end
                // A new frame starting during DONE goes straight back to SHIFT
                if (cs_fall_s) begin
                    state_next_s = SHIFT;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Shift register and saturating bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r <= '0;
            cnt_r   <= 6'd0;
        end else if (start_s) begin
            shreg_r <= '0;
            cnt_r   <= 6'd0;
        end else if (shift_en_s) begin
            if (cnt_r < FRAME_BITS_W) begin
                shreg_r <= {shreg_r[FRAME_BITS-2:0], mosi_sync_r[1]};
            end
            if (cnt_r != 6'd63) begin
                cnt_r <= cnt_r + 6'd1;
            end
        end
    end

    // Registered frame outputs and strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_data_r  <= '0;
            frame_count_r <= 16'd0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            frame_valid_r <= accept_s;
            frame_err_r   <= reject_s;
            busy_r        <= (state_next_s == SHIFT);
            if (accept_s) begin
                frame_data_r  <= shreg_r;
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    assign bus.frame_data  = frame_data_r;
    assign bus.a_val       = frame_data_r[39:32];
    assign bus.b_val       = frame_data_r[31:24];
    assign bus.acc_val     = frame_data_r[23:16];
    assign bus.pc_val      = frame_data_r[11:8];
    assign bus.state_val   = frame_data_r[2:0];
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.frame_count = frame_count_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: bit-banged SPI frames with hand-computed results.
module tb_spi_frame_receiver;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    int   both_high = 0;
    logic [39:0] cap[$];
    logic [63:0] d41;
    int   err_before;
    bit   exp_fmt_valid;

    spi_frame_receiver_if #(.FRAME_BITS(40)) bus ();

    spi_frame_receiver #(.FRAME_BITS(40), .SAMPLE_FALLING(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor
    always @(negedge clk) begin
        if (bus.frame_valid) cap.push_back(bus.frame_data);
        if (bus.frame_err) err_pulses++;
        if (bus.frame_valid && bus.frame_err) both_high++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive nbits of data MSB-first; launch on sclk rise, slave samples on fall; cs_n left low
    task automatic spi_bits(input logic [63:0] data, input int nbits, input int half);
        bus.cs_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.sclk = 1'b1;
            bus.mosi = data[i];
            repeat (half) @(negedge clk);
            bus.sclk = 1'b0;
            repeat (half) @(negedge clk);
        end
    endtask

    // Raise cs_n and check the strobe appears exactly on the 4th cycle for one cycle
    task automatic release_and_check(input string tag, input bit exp_valid);
        bus.cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, " pre"}, {62'd0, bus.frame_valid, bus.frame_err}, 64'd0);
        @(negedge clk);
        check({tag, " strobe"}, {62'd0, bus.frame_valid, bus.frame_err},
              {62'd0, exp_valid, ~exp_valid});
        @(negedge clk);
        check({tag, " post"}, {62'd0, bus.frame_valid, bus.frame_err}, 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset frame_data", {24'd0, bus.frame_data}, 64'd0);
        check("reset count", {48'd0, bus.frame_count}, 64'd0);
        check("reset strobes/busy", {61'd0, bus.frame_valid, bus.frame_err, bus.busy}, 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Nominal frame at 250 kHz
        spi_bits(64'h0A040E0305, 40, 200);
        check("nominal busy", {63'd0, bus.busy}, 64'd1);
        release_and_check("nominal", 1'b1);
        check("nominal data", {24'd0, bus.frame_data}, 64'h0A040E0305);
        check("nominal fields", {29'd0, bus.a_val, bus.b_val, bus.acc_val, bus.pc_val, bus.state_val},
              {29'd0, 8'h0A, 8'h04, 8'h0E, 4'd3, 3'd5});
        check("nominal count", {48'd0, bus.frame_count}, 64'd1);
        check("idle busy", {63'd0, bus.busy}, 64'd0);
        repeat (6) @(negedge clk);

        // 41 edges: trailing bit ignored
        d41 = {23'd0, 40'h0A040E0305, 1'b0};
        spi_bits(d41, 41, 8);
        release_and_check("41edge", 1'b1);
        check("41edge data", {24'd0, bus.frame_data}, 64'h0A040E0305);
        check("41edge count", {48'd0, bus.frame_count}, 64'd2);
        check("41edge no err", err_pulses, 64'd0);
        repeat (6) @(negedge clk);

        // Short frame
        spi_bits(64'h12345, 20, 8);
        release_and_check("short", 1'b0);
        check("short data kept", {24'd0, bus.frame_data}, 64'h0A040E0305);
        check("short count kept", {48'd0, bus.frame_count}, 64'd2);
        repeat (6) @(negedge clk);

        // Reset mid-frame
        err_before = err_pulses;
        spi_bits(64'h1FFFF, 17, 8);
        reset = 1'b1;
        @(negedge clk);
        check("midreset data", {24'd0, bus.frame_data}, 64'd0);
        check("midreset count/busy", {47'd0, bus.frame_count, bus.busy}, 64'd0);
        check("midreset a_val", {56'd0, bus.a_val}, 64'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("discard busy", {63'd0, bus.busy}, 64'd0);
        bus.cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("discard no strobe", err_pulses - err_before, 64'd0);
        spi_bits(64'hFF01000F00, 40, 8);
        release_and_check("after reset", 1'b1);
        check("after reset a_val", {56'd0, bus.a_val}, 64'hFF);
        check("after reset pc", {60'd0, bus.pc_val}, 64'hF);
        check("after reset count", {48'd0, bus.frame_count}, 64'd1);
        repeat (6) @(negedge clk);

        // Back-to-back with a 4-cycle cs_n gap
        cap.delete();
        spi_bits(64'h1122330102, 40, 8);
        bus.cs_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_bits(64'h3344550A04, 40, 8);
        release_and_check("b2b second", 1'b1);
        check("b2b pulses", cap.size(), 64'd2);
        if (cap.size() == 2) begin
            check("b2b first data", {24'd0, cap[0]}, 64'h1122330102);
            check("b2b second data", {24'd0, cap[1]}, 64'h3344550A04);
        end
        check("b2b count", {48'd0, bus.frame_count}, 64'd3);
        repeat (6) @(negedge clk);

        // Format-sensitive frames
`ifdef SPI_RX_FORMAT_CHECK_EN
        exp_fmt_valid = 1'b0;
`else
        exp_fmt_valid = 1'b1;
`endif
        spi_bits(64'h0102030006, 40, 8);
        release_and_check("state 6", exp_fmt_valid);
        repeat (6) @(negedge clk);
        spi_bits(64'h0102030010, 40, 8);
        release_and_check("reserved bit4", exp_fmt_valid);
        check("fmt count", {48'd0, bus.frame_count}, exp_fmt_valid ? 64'd5 : 64'd3);

        check("strobe exclusivity", both_high, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
